// File: rtl/mult_pkg.sv
// Shared FSM state type and default operand geometry for the digit-serial multiplier.
package mult_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/digit_mult.sv
// Combinational DIGIT x DIGIT unsigned multiplier producing a 2*DIGIT-bit result.
import mult_pkg::*;

module digit_mult #(
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0]   x,
    input  logic [DIGIT-1:0]   y,
    output logic [2*DIGIT-1:0] p
);
    localparam int PW = 2 * DIGIT;

    assign p = PW'(x) * PW'(y);
endmodule

// File: rtl/digit_serial_mult.sv
// Digit-serial unsigned multiplier: one DIGITxDIGIT partial product per cycle over M*M cycles.
// Define MULT_MAC_EN to add the acc_en port, which keeps the previous product as accumulator.
import mult_pkg::*;

module digit_serial_mult #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_MAC_EN
    input  logic               acc_en,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int M     = WIDTH / DIGIT;
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(M - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [DIGIT-1:0]   a_dig, b_dig;
    logic [2*DIGIT-1:0] pp;
    logic [PW-1:0]      pp_shift;

    assign a_dig = a_q[DIGIT*i_q +: DIGIT];
    assign b_dig = b_q[DIGIT*j_q +: DIGIT];

    digit_mult #(.DIGIT(DIGIT)) u_digit_mult (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    // Digit weights add: a digit i times b digit j lands at DIGIT*(i+j).
    assign pp_shift = PW'(pp) << (DIGIT * (int'(i_q) + int'(j_q)));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    i_d     = '0;
                    j_d     = '0;
`ifdef MULT_MAC_EN
                    prod_d  = acc_en ? prod_q : '0;
`else
                    prod_d  = '0;
`endif
                end
            end
            RUN: begin
                prod_d = prod_q + pp_shift;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;
endmodule
